// File: rtl/pll_acq_ctrl.sv
// Acquisition and lock sequencer for the PFD PLL: watches frequency-error samples,
// steps IDLE -> ACQ -> SETTLE -> TRACK and drives counter clear, loop mode and gain shifts.
module pll_acq_ctrl #(
  parameter int WIDTH      = 24,
  parameter int ACQ_THR    = 16,
  parameter int ACQ_CNT    = 4,
  parameter int LOSS_THR   = 64,
  parameter int LOSS_CNT   = 3,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT    = 1000,
  parameter int KP_ACQ     = 2,
  parameter int KI_ACQ     = 4,
  parameter int KP_TRK     = 5,
  parameter int KI_TRK     = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    fe_en,
  input  logic signed [WIDTH-1:0] fe_val,
  output logic                    fe_rst,
  output logic                    loop_mode,
  output logic [3:0]              kp_shift,
  output logic [3:0]              ki_shift,
  output logic                    locked,
  output logic                    lock_lost,
  output logic                    acq_fail,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    SETTLE = 2'd2,
    TRACK  = 2'd3
  } state_t;

  localparam int GW = $clog2(ACQ_CNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  localparam logic [GW-1:0] GOOD_LAST   = GW'(ACQ_CNT - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0] MISS_LAST   = MW'(LOSS_CNT - 1);

  localparam logic [WIDTH-1:0] ACQ_THR_W  = WIDTH'(ACQ_THR);
  localparam logic [WIDTH-1:0] LOSS_THR_W = WIDTH'(LOSS_THR);
  localparam logic [WIDTH-1:0] MAG_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  state_t          state_reg;
  state_t          state_next;
  logic [GW-1:0]   good_cnt_reg;
  logic [TW-1:0]   tmo_cnt_reg;
  logic [SW-1:0]   settle_cnt_reg;
  logic [MW-1:0]   miss_cnt_reg;

  logic [WIDTH-1:0] mag;
  logic             mag_good;
  logic             mag_bad;
  logic             sample_live;
  logic             tmo_hit;
  logic             good_hit;
  logic             settle_hit;
  logic             loss_hit;
  logic             acq_enter;
  logic             lost_next;
  logic             fail_next;

  // Two's-complement negation of the most-negative value would overflow, so clamp it.
  always_comb begin
    mag = $unsigned(fe_val);
    if (fe_val[WIDTH-1]) begin
      if ($unsigned(fe_val) == NEG_MIN) begin
        mag = MAG_MAX;
      end else begin
        mag = $unsigned(~fe_val) + 1'b1;
      end
    end
  end

  assign mag_good = (mag <= ACQ_THR_W);
  assign mag_bad  = (mag > LOSS_THR_W);

  // fe_rst marks the first ACQ cycle; the counter is still clearing, so its sample is stale.
  assign sample_live = fe_en && !fe_rst;

  assign tmo_hit    = en && (tmo_cnt_reg == TMO_LAST);
  assign good_hit   = sample_live && mag_good && (good_cnt_reg == GOOD_LAST);
  assign settle_hit = en && (settle_cnt_reg == SETTLE_LAST);
  assign loss_hit   = fe_en && mag_bad && (miss_cnt_reg == MISS_LAST);

  always_comb begin
    state_next = state_reg;
    acq_enter  = 1'b0;
    lost_next  = 1'b0;
    fail_next  = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = ACQ;
            acq_enter  = 1'b1;
          end
        end
        ACQ: begin
          if (tmo_hit) begin
            fail_next = 1'b1;
            acq_enter = 1'b1;
          end else if (good_hit) begin
            state_next = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_hit) begin
            state_next = TRACK;
          end
        end
        TRACK: begin
          if (loss_hit) begin
            state_next = ACQ;
            acq_enter  = 1'b1;
            lost_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      fe_rst         <= 1'b0;
      loop_mode      <= 1'b0;
      kp_shift       <= '0;
      ki_shift       <= '0;
      locked         <= 1'b0;
      lock_lost      <= 1'b0;
      acq_fail       <= 1'b0;
      good_cnt_reg   <= '0;
      tmo_cnt_reg    <= '0;
      settle_cnt_reg <= '0;
      miss_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      fe_rst    <= acq_enter;
      lock_lost <= lost_next;
      acq_fail  <= fail_next;
      locked    <= (state_next == TRACK);
      loop_mode <= (state_next == SETTLE) || (state_next == TRACK);

      case (state_next)
        ACQ: begin
          kp_shift <= 4'(KP_ACQ);
          ki_shift <= 4'(KI_ACQ);
        end
        SETTLE, TRACK: begin
          kp_shift <= 4'(KP_TRK);
          ki_shift <= 4'(KI_TRK);
        end
        default: begin
          kp_shift <= '0;
          ki_shift <= '0;
        end
      endcase

      // Any state change or ACQ re-entry starts every counter from zero.
      if ((state_next != state_reg) || acq_enter) begin
        good_cnt_reg   <= '0;
        tmo_cnt_reg    <= '0;
        settle_cnt_reg <= '0;
        miss_cnt_reg   <= '0;
      end else begin
        case (state_reg)
          ACQ: begin
            if (en && (tmo_cnt_reg != TMO_LAST)) begin
              tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
            if (sample_live) begin
              if (!mag_good) begin
                good_cnt_reg <= '0;
              end else if (good_cnt_reg != GOOD_LAST) begin
                good_cnt_reg <= good_cnt_reg + 1'b1;
              end
            end
          end
          SETTLE: begin
            if (en && (settle_cnt_reg != SETTLE_LAST)) begin
              settle_cnt_reg <= settle_cnt_reg + 1'b1;
            end
          end
          TRACK: begin
            if (fe_en) begin
              if (!mag_bad) begin
                miss_cnt_reg <= '0;
              end else if (miss_cnt_reg != MISS_LAST) begin
                miss_cnt_reg <= miss_cnt_reg + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state = state_reg;

endmodule
